// File: rtl/ofdm_pkg.sv
// Shared OFDM definitions: default symbol width, derived bit-index width and
// the serializer state enumeration.
package ofdm_pkg;

    localparam int unsigned DEF_FFT_SIZE  = 16;
    localparam int unsigned DEF_BIT_IDX_W = $clog2(DEF_FFT_SIZE);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bpsk_bit_serializer_if.sv
// Word-in / bit-out handshake bundle for the BPSK bit serializer.
// slave = the serializer itself, master = the surrounding logic.
interface bpsk_bit_serializer_if #(
    parameter int unsigned FFT_SIZE = ofdm_pkg::DEF_FFT_SIZE
);

    logic [FFT_SIZE-1:0] in_word;
    logic                in_valid;
    logic                in_ready;
    logic                out_bit;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;

    modport slave (
        input  in_word, in_valid, out_ready,
        output in_ready, out_bit, out_valid, out_last
    );

    modport master (
        output in_word, in_valid, out_ready,
        input  in_ready, out_bit, out_valid, out_last
    );

endinterface

// File: rtl/bpsk_bit_serializer.sv
// Serializes one demodulated BPSK symbol word into FFT_SIZE bits, subcarrier 0 first.
// Optional 16-bit completed-symbol counter under macro SYM_COUNT_EN.
module bpsk_bit_serializer
    import ofdm_pkg::*;
#(
    parameter int unsigned FFT_SIZE = DEF_FFT_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    bpsk_bit_serializer_if.slave  bus
`ifdef SYM_COUNT_EN
    ,
    output logic [15:0]           sym_count
`endif
);

    localparam int unsigned      IDX_W      = $clog2(FFT_SIZE);
    localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(FFT_SIZE - 2);

    state_t              r_state;
    logic [FFT_SIZE-1:0] r_shift;
    logic [IDX_W-1:0]    r_bit_idx;
    logic                r_valid;
    logic                r_last;

    logic w_xfer;
    logic w_in_ready;
    logic w_load;

    assign w_xfer = r_valid & bus.out_ready;

    // NOTE: in_ready is gated by rst_n because the state already decodes IDLE while reset is held.
    assign w_in_ready = rst_n & ~flush & ((r_state == IDLE) | (w_xfer & r_last));
    assign w_load     = bus.in_valid & w_in_ready;

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else if (flush) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_state   <= SHIFT;
            r_shift   <= bus.in_word;
            r_bit_idx <= '0;
            r_valid   <= 1'b1;
            r_last    <= 1'b0;
        end else if (w_xfer) begin
            r_shift <= r_shift >> 1;
            if (r_last) begin
                r_state   <= IDLE;
                r_bit_idx <= '0;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
            end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                r_last    <= (r_bit_idx == IDX_PENULT);
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_bit   = r_shift[0];
    assign bus.out_valid = r_valid;
    assign bus.out_last  = r_last;

`ifdef SYM_COUNT_EN
    logic [15:0] r_sym_count;

    // A flushed symbol never reaches its final transfer, so it is never counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sym_count <= '0;
        end else if (!flush && w_xfer && r_last) begin
            r_sym_count <= r_sym_count + 16'd1;
        end
    end

    assign sym_count = r_sym_count;
`endif

endmodule

// File: tb/tb_bpsk_bit_serializer.sv
// Self-checking bench for bpsk_bit_serializer: directed scenarios plus random
// traffic scored against a queue-based model of the symbol bit stream.
module tb_bpsk_bit_serializer;
    import ofdm_pkg::*;

    localparam int N = DEF_FFT_SIZE;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
`ifdef SYM_COUNT_EN
    logic [15:0] sym_count;
`endif

    bpsk_bit_serializer_if #(.FFT_SIZE(N)) bus ();

    bpsk_bit_serializer #(.FFT_SIZE(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus)
`ifdef SYM_COUNT_EN
        ,
        .sym_count (sym_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: bits still owed to the output, in emission order, with their last flags.
    bit          mq_bit[$];
    bit          mq_last[$];
    logic [15:0] exp_sym = '0;
    bit          got_bits[$];
    logic        obs_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        mq_bit.delete();
        mq_last.delete();
    endtask

    task automatic step(input logic iv, input logic [N-1:0] w, input logic ordy, input logic fl);
        logic exp_valid, exp_bit, exp_last, exp_ready;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_word   = w;
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        exp_valid = (mq_bit.size() > 0);
        exp_bit   = exp_valid ? mq_bit[0]  : 1'b0;
        exp_last  = exp_valid ? mq_last[0] : 1'b0;
        exp_ready = !fl && (mq_bit.size() == 0 || (mq_bit.size() == 1 && ordy));
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("out_bit",   32'(bus.out_bit),   32'(exp_bit));
        check("out_last",  32'(bus.out_last),  32'(exp_last));
        check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
`ifdef SYM_COUNT_EN
        check("sym_count", 32'(sym_count), 32'(exp_sym));
`endif
        obs_ready = bus.in_ready;
        if (bus.out_valid && ordy) got_bits.push_back(bus.out_bit);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            if (exp_valid && ordy) begin
                if (mq_last[0]) exp_sym = exp_sym + 16'd1;
                void'(mq_bit.pop_front());
                void'(mq_last.pop_front());
            end
            if (iv && exp_ready) begin
                for (int i = 0; i < N; i++) begin
                    mq_bit.push_back(w[i]);
                    mq_last.push_back(i == N - 1);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          seq_a5c3[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
        logic        rdy16;
        logic [15:0] sym_before;
        int          k;

        bus.in_valid  = 1'b0;
        bus.in_word   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        flush         = 1'b0;

        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_bit",   32'(bus.out_bit),   32'd0);
        check("rst_out_last",  32'(bus.out_last),  32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Single word, free-running sink.
        got_bits.delete();
        step(1'b1, 16'hA5C3, 1'b1, 1'b0);
        repeat (16) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("a5c3_count", 32'(got_bits.size()), 32'd16);
        if (got_bits.size() == 16)
            for (int i = 0; i < 16; i++) check("a5c3_bit", 32'(got_bits[i]), 32'(seq_a5c3[i]));

        // Back-to-back symbols with no bubble.
        got_bits.delete();
        rdy16 = 1'b0;
        step(1'b1, 16'hFFFF, 1'b1, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 16'h0000, 1'b1, 1'b0);
            if (i == 16) rdy16 = obs_ready;
        end
        repeat (16) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check("b2b_ready16", 32'(rdy16), 32'd1);
        check("b2b_count", 32'(got_bits.size()), 32'd32);
        if (got_bits.size() == 32)
            for (int i = 0; i < 32; i++) check("b2b_bit", 32'(got_bits[i]), (i < 16) ? 32'd1 : 32'd0);

        // Backpressure pattern 1,0,0,1 repeating.
        got_bits.delete();
        step(1'b1, 16'h8001, 1'b1, 1'b0);
        k = 0;
        while (got_bits.size() < 16 && k < 200) begin
            step(1'b0, '0, (k % 4 == 0) || (k % 4 == 3), 1'b0);
            k++;
        end
        check("stall_xfers", 32'(got_bits.size()), 32'd16);
        if (got_bits.size() == 16) begin
            check("stall_bit0",  32'(got_bits[0]),  32'd1);
            check("stall_bit7",  32'(got_bits[7]),  32'd0);
            check("stall_bit15", 32'(got_bits[15]), 32'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0);

        // Flush at bit 7, with a competing word offered that must be dropped.
        sym_before = exp_sym;
        step(1'b1, 16'h1234, 1'b1, 1'b0);
        repeat (7) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 16'hBEEF, 1'b1, 1'b1);
        check("flush_ready_low", 32'(obs_ready), 32'd0);
        step(1'b0, '0, 1'b0, 1'b0);
        check("post_flush_ready", 32'(obs_ready), 32'd1);
        check("post_flush_sym_model", 32'(exp_sym), 32'(sym_before));
        step(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-symbol.
        step(1'b1, 16'h5A5A, 1'b1, 1'b0);
        repeat (5) step(1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check("arst_out_bit",   32'(bus.out_bit),   32'd0);
        check("arst_out_last",  32'(bus.out_last),  32'd0);
        check("arst_in_ready",  32'(bus.in_ready),  32'd0);
`ifdef SYM_COUNT_EN
        check("arst_sym_count", 32'(sym_count), 32'd0);
`endif
        model_clear();
        exp_sym = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b1, 1'b0);

        // Random traffic against the model.
        repeat (3000) begin
            step(1'($urandom_range(0, 1)), N'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
